// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the CNN datapath front end (row_packer and
//   input_array): default lane count, word width and the packer state type.
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int CNN_LANES = 32;
   localparam int CNN_DW    = 16;

   typedef enum logic [2:0] {
      PK_IDLE  = 3'd0,
      PK_FILL  = 3'd1,
      PK_PUSH  = 3'd2,
      PK_DRAIN = 3'd3,
      PK_DONE  = 3'd4
   } pk_state_e;

   // Counter width for an index range of n values, never narrower than 1 bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/row_packer.sv
// ---------------------------------------------------------------------------
// row_packer
//   Collects a serial word stream into rows of LANES words and presents each
//   full row in parallel to input_array, then flushes the array skew with
//   LANES-1 all-zero rows before reporting the tile finished.
//
// Ports
//   clk       sole clock, rising edge
//   nrst      synchronous reset, active high
//   start     one-cycle tile request, honoured only in IDLE
//   num_rows  rows in the tile, latched with start
//   s_data    serial word stream
//   s_valid   s_data valid
//   s_ready   a beat transfers when s_valid && s_ready
//   data_out  packed row (lane k = k-th accepted word of the row)
//   fifo_en   data_out valid this cycle
//   busy      high outside IDLE
//   done      one-cycle pulse at the end of the tile (after drain)
//
// State table
//   state | meaning
//   IDLE  | waiting for start, stream not accepted
//   FILL  | accepting words into the row register, lane 0 first
//   PUSH  | one cycle presenting the full row, row counter advances
//   DRAIN | LANES-1 cycles of zero rows flushing the array skew
//   DONE  | one-cycle done pulse, returns to IDLE
// ---------------------------------------------------------------------------
module row_packer
   import cnn_pkg::*;
#(
   parameter int LANES = CNN_LANES,
   parameter int DW    = CNN_DW,
   parameter int RW    = 6
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          start,
   input  logic [RW-1:0] num_rows,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [DW-1:0] data_out [LANES-1:0],
   output logic          fifo_en,
   output logic          busy,
   output logic          done
);

   localparam int WCW = cnt_width(LANES);

   pk_state_e     r_state;
   logic [WCW-1:0] r_word_cnt;
   logic [RW-1:0]  r_row_cnt;
   logic [RW-1:0]  r_num_rows;
   logic [WCW-1:0] r_drain_cnt;
   logic [DW-1:0]  r_row      [LANES-1:0];
   logic [DW-1:0]  r_data_out [LANES-1:0];
   logic           r_s_ready;
   logic           r_fifo_en;
   logic           r_busy;
   logic           r_done;

   pk_state_e     w_state_nxt;
   logic [WCW-1:0] w_word_cnt_nxt;
   logic [RW-1:0]  w_row_cnt_nxt;
   logic [RW-1:0]  w_num_rows_nxt;
   logic [WCW-1:0] w_drain_cnt_nxt;
   logic [DW-1:0]  w_row_nxt      [LANES-1:0];
   logic [DW-1:0]  w_data_out_nxt [LANES-1:0];
   logic           w_s_ready_nxt;
   logic           w_fifo_en_nxt;
   logic           w_busy_nxt;
   logic           w_done_nxt;
   logic           w_beat;
   logic           w_last_word;
   logic [RW-1:0]  w_row_cnt_inc;

   // s_ready is high exactly while in FILL, so the state alone qualifies a beat.
   assign w_beat        = (r_state == PK_FILL) && s_valid;
   assign w_last_word   = (r_word_cnt == WCW'(LANES - 1));
   assign w_row_cnt_inc = r_row_cnt + RW'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_word_cnt_nxt  = r_word_cnt;
      w_row_cnt_nxt   = r_row_cnt;
      w_num_rows_nxt  = r_num_rows;
      w_drain_cnt_nxt = r_drain_cnt;
      w_row_nxt       = r_row;

      case (r_state)
         PK_IDLE: begin
            if (start) begin
               w_num_rows_nxt = num_rows;
               w_word_cnt_nxt = '0;
               w_row_cnt_nxt  = '0;
               w_state_nxt    = (num_rows == '0) ? PK_DONE : PK_FILL;
            end
         end

         PK_FILL: begin
            if (w_beat) begin
               for (int i = 0; i < LANES; i++) begin
                  if (r_word_cnt == WCW'(i)) begin
                     w_row_nxt[i] = s_data;
                  end
               end
               if (w_last_word) begin
                  w_word_cnt_nxt = '0;
                  w_state_nxt    = PK_PUSH;
               end else begin
                  w_word_cnt_nxt = r_word_cnt + WCW'(1);
               end
            end
         end

         PK_PUSH: begin
            w_row_cnt_nxt = w_row_cnt_inc;
            if (w_row_cnt_inc == r_num_rows) begin
               // Down-counter reaches zero on the last of LANES-1 drain cycles.
               w_drain_cnt_nxt = WCW'(LANES - 2);
               w_state_nxt     = PK_DRAIN;
            end else begin
               w_word_cnt_nxt = '0;
               w_state_nxt    = PK_FILL;
            end
         end

         PK_DRAIN: begin
            if (r_drain_cnt == '0) begin
               w_state_nxt = PK_DONE;
            end else begin
               w_drain_cnt_nxt = r_drain_cnt - WCW'(1);
            end
         end

         PK_DONE: begin
            w_state_nxt = PK_IDLE;
         end

         default: begin
            w_state_nxt = PK_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state.
      w_s_ready_nxt = (w_state_nxt == PK_FILL);
      w_fifo_en_nxt = (w_state_nxt == PK_PUSH) || (w_state_nxt == PK_DRAIN);
      w_busy_nxt    = (w_state_nxt != PK_IDLE);
      w_done_nxt    = (w_state_nxt == PK_DONE);

      w_data_out_nxt = r_data_out;
      if (w_state_nxt == PK_PUSH) begin
         // Includes the word landing on the final lane in this same cycle.
         w_data_out_nxt = w_row_nxt;
      end else if (w_state_nxt == PK_DRAIN) begin
         for (int i = 0; i < LANES; i++) begin
            w_data_out_nxt[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         r_state     <= PK_IDLE;
         r_word_cnt  <= '0;
         r_row_cnt   <= '0;
         r_num_rows  <= '0;
         r_drain_cnt <= '0;
         r_s_ready   <= 1'b0;
         r_fifo_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            r_row[i]      <= '0;
            r_data_out[i] <= '0;
         end
      end else begin
         r_state     <= w_state_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
         r_row_cnt   <= w_row_cnt_nxt;
         r_num_rows  <= w_num_rows_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
         r_s_ready   <= w_s_ready_nxt;
         r_fifo_en   <= w_fifo_en_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_row       <= w_row_nxt;
         r_data_out  <= w_data_out_nxt;
      end
   end

   assign s_ready  = r_s_ready;
   assign fifo_en  = r_fifo_en;
   assign busy     = r_busy;
   assign done     = r_done;
   assign data_out = r_data_out;

endmodule

// File: doc/row_packer.md
ROW_PACKER -- requirements
Module: row_packer

Interface
REQ-001: Parameter LANES, default 32, number of parallel output lanes (one word per input_array lane).
REQ-002: Parameter DW, default 16, word width in bits.
REQ-003: Parameter RW, default 6, width of the row-count input.
REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005: nrst  input  1  synchronous, active-high reset; asserted = 1, sampled on clk rising edge.
REQ-006: start  input  1  one-cycle request to begin a tile; sampled only in IDLE.
REQ-007: num_rows  input  RW  rows in the tile; latched when start is accepted.
REQ-008: s_data  input  DW  serial word stream.
REQ-009: s_valid  input  1  s_data valid.
REQ-010: s_ready  output  1  packer can accept a word; a beat transfers when s_valid && s_ready.
REQ-011: data_out  output  DW x LANES (unpacked array [LANES-1:0])  packed row presented to input_array data_in.
REQ-012: fifo_en  output  1  data_out valid this cycle; drives input_array fifo_en.
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: done  output  1  one-cycle pulse when the tile, including drain, is finished.

Function
REQ-015: FSM states are IDLE, FILL, PUSH, DRAIN and DONE; all outputs are registered.
REQ-016: IDLE: s_ready=0, fifo_en=0; start=1 latches num_rows, clears word_cnt/row_cnt, moves to FILL, or to DONE when num_rows=0.
REQ-017: IDLE with start=0 remains IDLE; start in any other state is ignored.
REQ-018: FILL: s_ready=1; accepted beat k (k=0..LANES-1) is written to lane k of the row register, so the first word lands on lane 0.
REQ-019: FILL: cycles with s_valid=0 hold all state; no timeout.
REQ-020: The accepted beat with word_cnt=LANES-1 moves to PUSH; s_ready is 0 from the next cycle.
REQ-021: PUSH lasts exactly one cycle: fifo_en=1, data_out=row register, row_cnt increments.
REQ-022: PUSH exits to DRAIN when row_cnt+1 = latched num_rows, otherwise to FILL with word_cnt=0.
REQ-023: Latency: fifo_en rises on the cycle after the LANES-th accepted beat; one-cycle bubble per row, with s_ready=0 during PUSH.
REQ-024: DRAIN: fifo_en=1 and data_out all zeros for exactly LANES-1 consecutive cycles to flush the input_array skew, then DONE.
REQ-025: DONE: done=1 for one cycle, busy=1, fifo_en=0, then IDLE.
REQ-026: Outside PUSH/DRAIN, fifo_en=0 and data_out holds its last value.
REQ-027: s_valid outside FILL is ignored; no beat is consumed and no state changes.
REQ-028: word_cnt is ceil(log2(LANES)) bits wide and row_cnt is RW bits wide; no wrap-around occurs within a legal tile.
REQ-029: Continuous streaming of R>0 rows: done asserts R*(LANES+1)+LANES cycles after the cycle start is accepted.

Reset
REQ-030: nrst=1 forces IDLE and zeroes word_cnt, row_cnt, drain counter, row register, data_out, fifo_en, s_ready, busy and done on the next clk edge.
REQ-031: nrst asserted mid-tile (FILL, PUSH or DRAIN) abandons the tile with no done pulse; a partial row is discarded.
REQ-032: start coincident with nrst=1 is ignored.

Structure
REQ-033: LANES and DW defaults and the state enum type belong in the shared package cnn_pkg, shared with input_array.
REQ-034: Single flat module with no sub-module; the counters and row register live in one always_ff block and the next-state logic in one always_comb block.

Verification
REQ-035: Reset, then num_rows=1 and words 1..32 streamed with s_valid held high -> one fifo_en cycle with data_out[i]=i+1, then 31 zero-row cycles, and done 65 cycles after start.
REQ-036: num_rows=3 with s_valid toggling 1,0 -> exactly 3 PUSH cycles, row contents match sent words in order, and s_ready=0 in PUSH/DRAIN/DONE.
REQ-037: start with num_rows=0 -> DONE on the next cycle, done pulse, and no fifo_en and no s_ready at any time.
REQ-038: nrst=1 after 10 beats of row 0 -> all outputs 0 next cycle and no done pulse; a following num_rows=1 tile packs from lane 0 correctly.
REQ-039: start re-pulsed during FILL and s_valid=1 during DRAIN -> tile unaffected, no extra beats consumed, and done timing is unchanged.
REQ-040: Connect to input_array with num_rows=2 -> out_vld is asserted for every lane and the last nonzero word exits lane 31 before done.
